// File: rtl/seq_alu_core.sv
// -----------------------------------------------------------------------------
// seq_alu_core
//
// Sequential unsigned ALU with valid/ready handshakes on both sides.
// ADD and SUB finish at the accept edge. MUL (shift-add) and DIV (restoring)
// iterate one bit per cycle for WIDTH cycles. DIV by zero finishes at the
// accept edge with flag_dbz set.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. The
// producer must hold op/a/b stable while in_valid is high and in_ready is low.
// The block holds its result stable while out_valid is high and out_ready is
// low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   op                    00 ADD, 01 SUB, 10 MUL, 11 DIV
//   a, b                  unsigned operands
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result_lo, result_hi  low/high result words
//   flag_carry            ADD carry, SUB borrow, MUL hi!=0, DIV 0
//   flag_zero             both result words are 0
//   flag_dbz              DIV issued with b==0
//   busy                  iterative operation in progress
//
// The FSM state is fully visible on the ports: in_ready = IDLE,
// busy = BUSY, out_valid = DONE.
// -----------------------------------------------------------------------------
module seq_alu_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_carry,
   output logic             flag_zero,
   output logic             flag_dbz,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   // MUL: {upper accumulator, multiplier}; DIV: {remainder, quotient/dividend}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // MUL multiplicand or DIV divisor
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   result_lo_q, result_lo_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic               dbz_q, dbz_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   // Single-cycle datapath
   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   sub_diff;

   // One shift-add multiply step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   // One restoring-divide step. The shifted remainder needs WIDTH+1 bits
   // because it can reach 2*b-1.
   logic [WIDTH:0]     div_sh;
   logic               div_borrow;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] step_next;
   logic               accept;

   always_comb begin
      add_sum  = {1'b0, a} + {1'b0, b};
      sub_diff = a - b;

      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      div_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_borrow = (div_sh < {1'b0, opb_q});
      // When there is no borrow the true difference is below b, so the
      // truncated subtraction is exact.
      div_diff   = div_sh[WIDTH-1:0] - opb_q;
      div_rem    = div_borrow ? div_sh[WIDTH-1:0] : div_diff;
      div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};

      step_next  = is_div_q ? div_next : mul_next;
      accept     = in_valid && in_ready_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      dbz_d       = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_ADD: begin
                     result_lo_d = add_sum[WIDTH-1:0];
                     result_hi_d = '0;
                     carry_d     = add_sum[WIDTH];
                     zero_d      = (add_sum[WIDTH-1:0] == '0);
                     dbz_d       = 1'b0;
                     state_d     = S_DONE;
                  end
                  OP_SUB: begin
                     result_lo_d = sub_diff;
                     result_hi_d = '0;
                     carry_d     = (a < b);
                     zero_d      = (sub_diff == '0);
                     dbz_d       = 1'b0;
                     state_d     = S_DONE;
                  end
                  OP_MUL: begin
                     acc_d    = {{WIDTH{1'b0}}, a};
                     opb_d    = b;
                     is_div_d = 1'b0;
                     cnt_d    = CW'(WIDTH);
                     state_d  = S_BUSY;
                  end
                  OP_DIV: begin
                     if (b == '0) begin
                        result_lo_d = '0;
                        result_hi_d = '0;
                        carry_d     = 1'b0;
                        zero_d      = 1'b1;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, a};
                        opb_d    = b;
                        is_div_d = 1'b1;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_BUSY;
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_BUSY: begin
            acc_d = step_next;
            cnt_d = cnt_q - CW'(1);
            // Last step: register the result on the edge the counter hits 0
            if (cnt_q == CW'(1)) begin
               result_lo_d = step_next[WIDTH-1:0];
               result_hi_d = step_next[2*WIDTH-1:WIDTH];
               carry_d     = !is_div_q && (step_next[2*WIDTH-1:WIDTH] != '0);
               zero_d      = (step_next == '0);
               dbz_d       = 1'b0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered copies of the next state
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_div_q    <= 1'b0;
         acc_q       <= '0;
         opb_q       <= '0;
         result_lo_q <= '0;
         result_hi_q <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_div_q    <= is_div_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         result_lo_q <= result_lo_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign result_lo  = result_lo_q;
   assign result_hi  = result_hi_q;
   assign flag_carry = carry_q;
   assign flag_zero  = zero_q;
   assign flag_dbz   = dbz_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// -----------------------------------------------------------------------------
// tb_seq_alu_core
//
// Drives one WIDTH=8 and one WIDTH=16 instance of seq_alu_core (one active at
// a time) with directed and random operations. Expected results come from an
// arithmetic reference model using plain integer +,-,*,/,%.
// -----------------------------------------------------------------------------
module tb_seq_alu_core;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  op;
   logic [15:0] a_v, b_v;
   logic        out_ready;
   logic        in_valid8, in_valid16;

   logic        in_ready8, out_valid8, carry8, zero8, dbz8, busy8;
   logic [7:0]  lo8, hi8;
   logic        in_ready16, out_valid16, carry16, zero16, dbz16, busy16;
   logic [15:0] lo16, hi16;

   seq_alu_core #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op), .a(a_v[7:0]), .b(b_v[7:0]), .out_valid(out_valid8),
      .out_ready(out_ready), .result_lo(lo8), .result_hi(hi8),
      .flag_carry(carry8), .flag_zero(zero8), .flag_dbz(dbz8), .busy(busy8)
   );

   seq_alu_core #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .op(op), .a(a_v), .b(b_v), .out_valid(out_valid16),
      .out_ready(out_ready), .result_lo(lo16), .result_hi(hi16),
      .flag_carry(carry16), .flag_zero(zero16), .flag_dbz(dbz16), .busy(busy16)
   );

   // ---------------- bookkeeping ----------------
   int          n_checks = 0;
   int          n_err    = 0;
   int          cur_w    = 8;
   bit          sel16    = 1'b0;
   logic [34:0] exp_q[$];   // {carry, zero, dbz, hi[15:0], lo[15:0]}

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s (w=%0d) observed=%0h expected=%0h", tag, cur_w, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [34:0] model(input int w, input logic [1:0] o,
                                          input logic [15:0] x, input logic [15:0] y);
      logic [63:0] m, xa, yb, p, lo, hi;
      logic        c, z, d;
      m  = (64'd1 << w) - 64'd1;
      xa = {48'd0, x} & m;
      yb = {48'd0, y} & m;
      lo = 0; hi = 0; c = 1'b0; d = 1'b0;
      case (o)
         2'd0: begin p = xa + yb; lo = p & m; c = ((p >> w) != 0); end
         2'd1: begin lo = (xa - yb) & m; c = (xa < yb); end
         2'd2: begin p = xa * yb; lo = p & m; hi = p >> w; c = (hi != 0); end
         default: begin
            if (yb == 0) d = 1'b1;
            else begin lo = xa / yb; hi = xa % yb; end
         end
      endcase
      z = (lo == 0) && (hi == 0);
      return {c, z, d, hi[15:0], lo[15:0]};
   endfunction

   function automatic int exp_lat(input int w, input logic [1:0] o, input logic [15:0] y);
      logic [15:0] yb;
      yb = (w == 16) ? y : {8'd0, y[7:0]};
      if (o == 2'd2 || (o == 2'd3 && yb != 0)) return w + 1;
      return 1;
   endfunction

   // ---------------- observation of the active instance ----------------
   function automatic logic [34:0] res();
      if (sel16) return {carry16, zero16, dbz16, hi16, lo16};
      return {carry8, zero8, dbz8, 8'd0, hi8, 8'd0, lo8};
   endfunction
   function automatic logic rdy(); return sel16 ? in_ready16 : in_ready8; endfunction
   function automatic logic ov();  return sel16 ? out_valid16 : out_valid8; endfunction
   function automatic logic bsy(); return sel16 ? busy16 : busy8; endfunction

   task automatic set_valid(input logic v);
      if (sel16) in_valid16 = v;
      else       in_valid8  = v;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int k;
      k = 0;
      while (!rdy() && k < 50) begin @(negedge clk); k++; end
      check("in_ready_before_issue", rdy(), 1);
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_after_drain", ov(), 0);
      check("in_ready_after_drain", rdy(), 1);
   endtask

   // Issue one op, measure latency and busy cycles, check the result,
   // optionally hold backpressure for 'hold' cycles, then drain.
   task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input int hold, input bit scramble);
      logic [34:0] e;
      int lat, bcnt, el;
      @(negedge clk);
      wait_ready();
      op = o; a_v = x; b_v = y;
      set_valid(1'b1);
      exp_q.push_back(model(cur_w, o, x, y));
      el = exp_lat(cur_w, o, y);
      @(posedge clk); #1;
      set_valid(1'b0);
      lat = 1; bcnt = 0;
      while (!ov() && lat < 100) begin
         if (bsy()) bcnt++;
         if (scramble) begin
            a_v = 16'($urandom); b_v = 16'($urandom); op = 2'($urandom);
            set_valid(1'($urandom_range(0, 1)));
         end
         @(posedge clk); #1;
         lat++;
      end
      set_valid(1'b0);
      e = exp_q.pop_front();
      check("latency", lat, el);
      check("busy_cycles", bcnt, el - 1);
      check("result", res(), e);
      check("in_ready_in_done", rdy(), 0);
      check("busy_in_done", bsy(), 0);
      for (int k = 0; k < hold; k++) begin
         a_v = 16'($urandom); b_v = 16'($urandom);
         @(posedge clk); #1;
         check("result_held", res(), e);
         check("out_valid_held", ov(), 1);
         check("in_ready_held", rdy(), 0);
      end
      drain();
   endtask

   // Result held under backpressure while a second request waits.
   task automatic bp_test();
      logic [34:0] e1, e2;
      logic [15:0] x2, y2;
      @(negedge clk);
      wait_ready();
      op = 2'd0; a_v = 16'($urandom); b_v = 16'($urandom);
      e1 = model(cur_w, 2'd0, a_v, b_v);
      set_valid(1'b1);
      @(posedge clk); #1;
      check("bp_first_valid", ov(), 1);
      check("bp_first_result", res(), e1);
      x2 = 16'($urandom); y2 = 16'($urandom);
      op = 2'd1; a_v = x2; b_v = y2;   // request stays asserted throughout
      e2 = model(cur_w, 2'd1, x2, y2);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_result_stable", res(), e1);
         check("bp_out_valid", ov(), 1);
         check("bp_in_ready_low", rdy(), 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_drain_out_valid", ov(), 0);
      check("bp_drain_in_ready", rdy(), 1);
      @(posedge clk); #1;
      set_valid(1'b0);
      check("bp_second_valid", ov(), 1);
      check("bp_second_result", res(), e2);
      drain();
   endtask

   // Reset during the 4th BUSY cycle of a MUL aborts it.
   task automatic reset_mid_busy();
      int seen;
      @(negedge clk);
      wait_ready();
      op = 2'd2; a_v = 16'hFFFF; b_v = 16'hFFFF;
      set_valid(1'b1);
      @(posedge clk); #1;
      set_valid(1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("busy_before_reset", bsy(), 1);
      rst_n = 1'b0;
      #1;
      check("rst_result", res(), 0);
      check("rst_out_valid", ov(), 0);
      check("rst_busy", bsy(), 0);
      check("rst_in_ready", rdy(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < cur_w + 4; k++) begin
         @(posedge clk); #1;
         if (ov() || bsy()) seen++;
      end
      check("no_output_after_abort", seen, 0);
      check("in_ready_after_abort", rdy(), 1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [15:0] mx, ra, rb;
      rst_n = 1'b0; op = 2'd0; a_v = '0; b_v = '0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_valid16 = 1'b0;
      #12;
      check("reset_w8_outputs", {in_ready8, out_valid8, busy8, carry8, zero8, dbz8, hi8, lo8}, 0);
      check("reset_w16_outputs", {in_ready16, out_valid16, busy16, carry16, zero16, dbz16, hi16, lo16}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_release", {in_ready16, in_ready8}, 2'b11);

      for (int pass = 0; pass < 2; pass++) begin
         sel16 = (pass == 1);
         cur_w = sel16 ? 16 : 8;
         mx    = sel16 ? 16'hFFFF : 16'h00FF;
         run_op(2'd0, 16'd200, 16'd100, 0, 0);
         run_op(2'd1, 16'd5, 16'd10, 0, 0);
         run_op(2'd1, 16'd7, 16'd7, 0, 0);
         run_op(2'd2, mx, mx, 0, 1);
         run_op(2'd3, 16'd200, 16'd7, 0, 1);
         run_op(2'd3, 16'd9, 16'd0, 0, 0);
         run_op(2'd2, 16'd0, 16'd123, 0, 0);
         run_op(2'd2, 16'd37, 16'd0, 0, 0);
         run_op(2'd3, mx, 16'd1, 0, 0);
         run_op(2'd3, 16'd3, mx, 0, 0);
         run_op(2'd0, mx, 16'd1, 1, 0);
         bp_test();
         for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom) & mx;
            rb = 16'($urandom) & mx;
            run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 2), 1);
         end
         reset_mid_busy();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
